slot_arbiter: RTL and testbench

- Time-slot round-robin arbiter sharing one resource between N requesters.
- Each grant lasts a programmable number of enabled cycles, timed by an internal wrap-on-maximum slot counter.
- A grant ends early if the owner drops its request.
- Sits in front of shared datapath resources (bus port, multiplier, memory bank) and drives their select/enable.

---
 rtl/slot_arbiter_pkg.sv | 10 +
 rtl/round_robin_next.sv | 95 +++++++++
 rtl/slot_arbiter.sv | 101 ++++++++++
 tb/tb_slot_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/slot_arbiter_pkg.sv
// rtl/slot_arbiter_pkg.sv - shared types for the time-slot round-robin arbiter
package slot_arbiter_pkg;

    // Arbiter state: IDLE means no owner, GRANT means a slot is running.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/round_robin_next.sv
// rtl/round_robin_next.sv - combinational round-robin winner search
//
// Ports:
//   req  : request vector
//   idx  : current/last owner; the search starts at idx+1 and ends at idx
//   excl : remove the owner from the candidate set (early release)
//   vld  : at least one candidate exists
//   nxt  : winning requester index (meaningful only when vld=1)
module round_robin_next #(
    parameter int N              = 4,
    parameter int IMPLEMENTATION = 0,
    parameter int IW             = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] idx,
    input  logic          excl,
    output logic          vld,
    output logic [IW-1:0] nxt
);

    // IMPLEMENTATION encodings
    localparam int IMPL_ROTATE = 0;  // rotate, priority encode, rotate back
    localparam int IMPL_DOUBLE = 1;  // double-width masked priority encode

    logic [N-1:0] req_m;

    always_comb begin
        req_m = req;
        if (excl) begin
            req_m[idx] = 1'b0;
        end
    end

    assign vld = |req_m;

    generate
        if (IMPLEMENTATION == IMPL_ROTATE) begin : g_rotate
            logic [N-1:0] rot;
            int           src;
            int           pos;

            always_comb begin
                rot = '0;
                src = 0;
                pos = 0;
                // rot[0] is requester idx+1, rot[N-1] is the owner itself
                for (int i = 0; i < N; i++) begin
                    src = int'(idx) + 1 + i;
                    if (src >= N) begin
                        src = src - N;
                    end
                    rot[i] = req_m[IW'(src)];
                end
                for (int i = N - 1; i >= 0; i--) begin
                    if (rot[i]) begin
                        pos = i;
                    end
                end
                src = int'(idx) + 1 + pos;
                if (src >= N) begin
                    src = src - N;
                end
                nxt = IW'(src);
            end
        end else if (IMPLEMENTATION == IMPL_DOUBLE) begin : g_double
            logic [2*N-1:0] dbl;
            int             pos;

            always_comb begin
                // Lower copy masked up to and including the owner; the upper
                // copy supplies the wrapped-around candidates.
                dbl = {req_m, req_m};
                pos = 0;
                for (int k = 0; k < N; k++) begin
                    if (k <= int'(idx)) begin
                        dbl[k] = 1'b0;
                    end
                end
                for (int k = 2*N - 1; k >= 0; k--) begin
                    if (dbl[k]) begin
                        pos = k;
                    end
                end
                if (pos >= N) begin
                    pos = pos - N;
                end
                nxt = IW'(pos);
            end
        end else begin : g_bad_impl
            $fatal(1, "round_robin_next: IMPLEMENTATION must be 0 or 1");
            assign nxt = '0;
        end
    endgenerate

endmodule

// File: rtl/slot_arbiter.sv
// rtl/slot_arbiter.sv - time-slot round-robin arbiter for one shared resource
//
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   ena      : slot time advance enable
//   req      : level-sensitive request per requester
//   max      : slot maximum; a slot lasts max+1 enabled cycles
//   act      : grant active
//   gnt      : one-hot grant, zero when idle
//   idx      : current/last owner
//   cnt      : slot counter
//   pls      : slot expiry pulse (combinational)
module slot_arbiter
    import slot_arbiter_pkg::*;
#(
    parameter int N              = 4,
    parameter int WIDTH          = 8,
    parameter int IMPLEMENTATION = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [N-1:0]         req,
    input  logic [WIDTH-1:0]     max,
    output logic                 act,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx,
    output logic [WIDTH-1:0]     cnt,
    output logic                 pls
);

    localparam int IW = $clog2(N);

    arb_state_t    state;
    logic          wrp;
    logic          rel;
    logic          slot_end;
    logic          vld;
    logic [IW-1:0] nxt;

    assign act = (state == ST_GRANT);

    // >= so that lowering max below the running count still expires the slot
    assign wrp      = (cnt >= max);
    assign pls      = act & ena & wrp;
    assign rel      = act & ~req[idx];
    assign slot_end = pls | rel;

    // On release the owner is excluded; on timer expiry it competes last.
    round_robin_next #(
        .N              (N),
        .IMPLEMENTATION (IMPLEMENTATION),
        .IW             (IW)
    ) u_rr (
        .req  (req),
        .idx  (idx),
        .excl (rel),
        .vld  (vld),
        .nxt  (nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            gnt   <= '0;
            idx   <= IW'(N - 1);
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (vld) begin
                        state <= ST_GRANT;
                        idx   <= nxt;
                        gnt   <= {{(N-1){1'b0}}, 1'b1} << nxt;
                        cnt   <= '0;
                    end
                end
                ST_GRANT: begin
                    if (slot_end) begin
                        cnt <= '0;
                        if (vld) begin
                            idx <= nxt;
                            gnt <= {{(N-1){1'b0}}, 1'b1} << nxt;
                        end else begin
                            state <= ST_IDLE;
                            gnt   <= '0;
                        end
                    end else if (ena) begin
                        cnt <= cnt + WIDTH'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gnt   <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_slot_arbiter.sv
// tb/tb_slot_arbiter.sv - scoreboard bench for slot_arbiter, both search variants and N=3
module tb_slot_arbiter;

    typedef struct packed {
        logic       act;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic [7:0] cnt;
        logic       pls;
    } obs_t;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [3:0] req;
    logic [7:0] max;

    logic       act0, act1, act2;
    logic [3:0] gnt0, gnt1;
    logic [2:0] gnt2;
    logic [1:0] idx0, idx1, idx2;
    logic [7:0] cnt0, cnt1, cnt2;
    logic       pls0, pls1, pls2;
    logic [2:0] req3;

    assign req3 = req[2:0];

    slot_arbiter #(.N(4), .WIDTH(8), .IMPLEMENTATION(0)) u0 (
        .clk(clk), .rst(rst), .ena(ena), .req(req), .max(max),
        .act(act0), .gnt(gnt0), .idx(idx0), .cnt(cnt0), .pls(pls0));

    slot_arbiter #(.N(4), .WIDTH(8), .IMPLEMENTATION(1)) u1 (
        .clk(clk), .rst(rst), .ena(ena), .req(req), .max(max),
        .act(act1), .gnt(gnt1), .idx(idx1), .cnt(cnt1), .pls(pls1));

    slot_arbiter #(.N(3), .WIDTH(8), .IMPLEMENTATION(0)) u2 (
        .clk(clk), .rst(rst), .ena(ena), .req(req3), .max(max),
        .act(act2), .gnt(gnt2), .idx(idx2), .cnt(cnt2), .pls(pls2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    obs_t q0[$];
    obs_t q1[$];
    obs_t q2[$];

    // Reference model state per DUT: owner flag, owner index, slot count.
    int m_act[3];
    int m_idx[3];
    int m_cnt[3];
    int nn[3] = '{4, 4, 3};

    // First set bit scanning owner+1, owner+2, ... wrapping, owner last.
    function automatic int winner(input int cand, input int owner, input int n);
        for (int k = 1; k <= n; k++) begin
            int c;
            c = (owner + k) % n;
            if (((cand >> c) & 1) != 0) return c;
        end
        return -1;
    endfunction

    task automatic step(input logic [3:0] r, input logic e, input logic [7:0] m, input logic rs);
        req = r;
        ena = e;
        max = m;
        rst = rs;
        for (int d = 0; d < 3; d++) begin
            int   n;
            int   rr;
            int   cand;
            bit   rel;
            obs_t o;
            n  = nn[d];
            rr = int'(r) & ((1 << n) - 1);
            if (rs) begin
                m_act[d] = 0;
                m_idx[d] = n - 1;
                m_cnt[d] = 0;
            end
            o.act = (m_act[d] != 0);
            o.gnt = (m_act[d] != 0) ? 4'(1 << m_idx[d]) : 4'd0;
            o.idx = 2'(m_idx[d]);
            o.cnt = 8'(m_cnt[d]);
            o.pls = (m_act[d] != 0) && e && (m_cnt[d] >= int'(m));
            case (d)
                0: q0.push_back(o);
                1: q1.push_back(o);
                default: q2.push_back(o);
            endcase
            if (!rs) begin
                if (m_act[d] == 0) begin
                    if (rr != 0) begin
                        m_act[d] = 1;
                        m_idx[d] = winner(rr, m_idx[d], n);
                        m_cnt[d] = 0;
                    end
                end else begin
                    rel = ((rr >> m_idx[d]) & 1) == 0;
                    if (rel || o.pls) begin
                        cand = rel ? (rr & ~(1 << m_idx[d])) : rr;
                        m_cnt[d] = 0;
                        if (cand != 0) begin
                            m_idx[d] = winner(cand, m_idx[d], n);
                        end else begin
                            m_act[d] = 0;
                        end
                    end else if (e) begin
                        m_cnt[d] = m_cnt[d] + 1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input obs_t got, input obs_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d got act=%b gnt=%b idx=%0d cnt=%0d pls=%b want act=%b gnt=%b idx=%0d cnt=%0d pls=%b",
                     name, cycle, got.act, got.gnt, got.idx, got.cnt, got.pls,
                     want.act, want.gnt, want.idx, want.cnt, want.pls);
        end
    endtask

    // Monitor: every driven cycle has one expected observation per DUT.
    always @(negedge clk) begin
        obs_t g;
        if (q0.size() != 0) begin
            g = '{act: act0, gnt: gnt0, idx: idx0, cnt: cnt0, pls: pls0};
            chk("n4_impl0", g, q0.pop_front());
        end
        if (q1.size() != 0) begin
            g = '{act: act1, gnt: gnt1, idx: idx1, cnt: cnt1, pls: pls1};
            chk("n4_impl1", g, q1.pop_front());
        end
        if (q2.size() != 0) begin
            g = '{act: act2, gnt: {1'b0, gnt2}, idx: idx2, cnt: cnt2, pls: pls2};
            chk("n3_impl0", g, q2.pop_front());
        end
        cycle++;
    end

    initial begin
        rst = 1'b1;
        ena = 1'b0;
        req = 4'd0;
        max = 8'd0;
        @(posedge clk);
        #1;

        // reset state
        repeat (2) step(4'b0000, 1'b1, 8'd2, 1'b1);
        repeat (2) step(4'b0000, 1'b1, 8'd2, 1'b0);

        // two requesters, max=2: 0 then 2 back-to-back
        repeat (6) step(4'b0101, 1'b1, 8'd2, 1'b0);
        repeat (2) step(4'b0000, 1'b1, 8'd2, 1'b0);

        // single requester re-granted every slot
        repeat (8) step(4'b0010, 1'b1, 8'd1, 1'b0);
        repeat (2) step(4'b0000, 1'b1, 8'd1, 1'b0);

        // owner 2 drops early with 3 waiting, then 3 drops with nobody left
        repeat (3) step(4'b0100, 1'b1, 8'd5, 1'b0);
        repeat (3) step(4'b1000, 1'b1, 8'd5, 1'b0);
        repeat (2) step(4'b0000, 1'b1, 8'd5, 1'b0);

        // ena pattern with single requester, then release during ena=0
        step(4'b0001, 1'b1, 8'd2, 1'b0);
        step(4'b0001, 1'b1, 8'd2, 1'b0);
        step(4'b0001, 1'b0, 8'd2, 1'b0);
        step(4'b0001, 1'b0, 8'd2, 1'b0);
        step(4'b0001, 1'b1, 8'd2, 1'b0);
        step(4'b0001, 1'b1, 8'd2, 1'b0);
        step(4'b0001, 1'b0, 8'd2, 1'b0);
        step(4'b0000, 1'b0, 8'd2, 1'b0);
        step(4'b0000, 1'b0, 8'd2, 1'b0);

        // lower max mid-slot
        repeat (6) step(4'b0010, 1'b1, 8'd7, 1'b0);
        repeat (3) step(4'b0010, 1'b1, 8'd1, 1'b0);
        repeat (2) step(4'b0000, 1'b1, 8'd1, 1'b0);

        // max=0: expiry on every enabled granted cycle
        repeat (6) step(4'b1011, 1'b1, 8'd0, 1'b0);

        // asynchronous reset mid-slot, then restart from requester 0
        repeat (5) step(4'b1111, 1'b1, 8'd5, 1'b0);
        step(4'b1111, 1'b1, 8'd5, 1'b1);
        repeat (4) step(4'b1111, 1'b1, 8'd5, 1'b0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [3:0] r;
            logic       e;
            logic [7:0] m;
            logic       rs;
            r  = 4'($urandom);
            e  = ($urandom_range(0, 3) != 0);
            m  = 8'($urandom_range(0, 4));
            rs = ($urandom_range(0, 63) == 0);
            step(r, e, m, rs);
        end

        @(negedge clk);
        #1;
        checks++;
        if (q0.size() + q1.size() + q2.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending entries want 0", q0.size() + q1.size() + q2.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
